// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_arb_pkg
// Description : Shared constants and types for the block-memory port arbiter.
//               MAX_REQ bounds the requester count, GRANT_COUNT_BITS sizes the
//               optional per-requester acceptance counters (BRAM_ARB_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

    localparam int MAX_REQ          = 8;
    localparam int GRANT_COUNT_BITS = 16;

    // Requester index, wide enough for the largest supported configuration
    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

endpackage : bram_arb_pkg
`default_nettype wire

// File: rtl/round_robin_picker.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_picker
// Description : Combinational round-robin selector. Searches upward from ptr,
//               wrapping at NUM_REQ-1, and reports the first valid index.
// Ports       : valid    - request present, per requester
//               ptr      - index with highest priority this cycle
//               grant    - one-hot winner (all zero when nothing is valid)
//               grant_id - index of the winner (0 when nothing is valid)
//               any      - at least one request is valid
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_picker
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] valid,
    input  req_id_t            ptr,
    output logic [NUM_REQ-1:0] grant,
    output req_id_t            grant_id,
    output logic               any
);

    // Requests at or above the pointer; these win over the wrapped-around ones
    logic [NUM_REQ-1:0] w_upper;

    always_comb begin
        w_upper = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_upper[i] = valid[i] && (i >= int'(ptr));
        end
    end

    // Descending scans: the last hit written is the lowest index, so the
    // upper half (scanned second) overrides the wrapped half when non-empty.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = |valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_id = req_id_t'(i);
            end
        end
        if (|w_upper) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_upper[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    grant_id = req_id_t'(i);
                end
            end
        end
    end

endmodule : round_robin_picker
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin arbiter sharing one block-memory port between
//               NUM_REQ requesters. One request accepted per cycle; read data
//               returns one cycle after acceptance with a per-requester strobe.
// Ports       : clk, reset_n (async, active low)
//               req_valid/req_ready/req_rd_en/req_address/req_wr_data/req_wr_en
//                   - per-requester request handshake and payload (flattened)
//               resp_valid/resp_rd_data - read response strobe and shared bus
//               mem_address/mem_rd_en/mem_wr_data/mem_wr_en/mem_rd_data
//                   - memory port (registered read, 1-cycle latency)
//               stats_clear/grant_count - only when BRAM_ARB_STATS_EN is defined
// Options     : BRAM_ARB_STATS_EN - saturating per-requester acceptance counters
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int CAPACITY_BYTES = 128,
    parameter  int BYTES_PER_WORD = 4,
    localparam int ADDR_BITS      = $clog2(CAPACITY_BYTES),
    localparam int WORD_BITS      = 8 * BYTES_PER_WORD
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_rd_en,
    input  logic [NUM_REQ*ADDR_BITS-1:0]      req_address,
    input  logic [NUM_REQ*WORD_BITS-1:0]      req_wr_data,
    input  logic [NUM_REQ*BYTES_PER_WORD-1:0] req_wr_en,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic [WORD_BITS-1:0]              resp_rd_data,
    output logic [ADDR_BITS-1:0]              mem_address,
    output logic                              mem_rd_en,
    output logic [WORD_BITS-1:0]              mem_wr_data,
    output logic [BYTES_PER_WORD-1:0]         mem_wr_en,
`ifdef BRAM_ARB_STATS_EN
    input  logic                              stats_clear,
    output logic [NUM_REQ*GRANT_COUNT_BITS-1:0] grant_count,
`endif
    input  logic [WORD_BITS-1:0]              mem_rd_data
);

    req_id_t            r_ptr;
    logic               r_pend_valid;
    req_id_t            r_pend_id;

    logic [NUM_REQ-1:0] w_pick;
    req_id_t            w_grant_id;
    logic               w_any;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_accept_rd;
    req_id_t            w_ptr_next;

    round_robin_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid    (req_valid),
        .ptr      (r_ptr),
        .grant    (w_pick),
        .grant_id (w_grant_id),
        .any      (w_any)
    );

    // Reset low must silence the handshake and memory strobes immediately,
    // not only at the next edge, so the grant is gated by reset_n.
    assign w_grant     = w_pick & {NUM_REQ{reset_n}};
    assign req_ready   = w_grant;
    assign w_accept_rd = |(w_grant & req_rd_en);
    assign w_ptr_next  = (w_grant_id == req_id_t'(NUM_REQ - 1)) ? '0
                                                                 : w_grant_id + req_id_t'(1);

    // Memory port: one-hot AND-OR select of the granted payload, zero otherwise
    always_comb begin
        mem_address = '0;
        mem_rd_en   = 1'b0;
        mem_wr_data = '0;
        mem_wr_en   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                mem_address = req_address[i*ADDR_BITS +: ADDR_BITS];
                mem_rd_en   = req_rd_en[i];
                mem_wr_data = req_wr_data[i*WORD_BITS +: WORD_BITS];
                mem_wr_en   = req_wr_en[i*BYTES_PER_WORD +: BYTES_PER_WORD];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_id    <= '0;
        end else begin
            if (w_any) begin
                r_ptr <= w_ptr_next;
            end
            r_pend_valid <= w_accept_rd;
            if (w_accept_rd) begin
                r_pend_id <= w_grant_id;
            end
        end
    end

    // Response: memory read data lands the cycle after acceptance
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = r_pend_valid && (r_pend_id == req_id_t'(i));
        end
        resp_rd_data = r_pend_valid ? mem_rd_data : '0;
    end

`ifdef BRAM_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [GRANT_COUNT_BITS-1:0] r_count;

        // Clear wins over a same-cycle increment; the count sticks at all-ones
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_count <= '0;
            end else if (stats_clear) begin
                r_count <= '0;
            end else if (w_grant[gi] && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end

        assign grant_count[gi*GRANT_COUNT_BITS +: GRANT_COUNT_BITS] = r_count;
    end
`endif

endmodule : bram_port_arbiter
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Self-checking bench for bram_port_arbiter: behavioural memory,
//               reference model (modulo round-robin search + shadow memory),
//               vector table, hand sequences and randomized traffic.
//               Exercises the counters when BRAM_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int N  = 4;
    localparam int AB = 7;
    localparam int WB = 32;
    localparam int BW = 4;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_rd_en;
    logic [N*AB-1:0] req_address;
    logic [N*WB-1:0] req_wr_data;
    logic [N*BW-1:0] req_wr_en;
    logic [N-1:0]    resp_valid;
    logic [WB-1:0]   resp_rd_data;
    logic [AB-1:0]   mem_address;
    logic            mem_rd_en;
    logic [WB-1:0]   mem_wr_data;
    logic [BW-1:0]   mem_wr_en;
    logic [WB-1:0]   mem_rd_data;
`ifdef BRAM_ARB_STATS_EN
    logic            stats_clear;
    logic [N*16-1:0] grant_count;
`endif

    bram_port_arbiter #(
        .NUM_REQ        (N),
        .CAPACITY_BYTES (128),
        .BYTES_PER_WORD (BW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd_en    (req_rd_en),
        .req_address  (req_address),
        .req_wr_data  (req_wr_data),
        .req_wr_en    (req_wr_en),
        .resp_valid   (resp_valid),
        .resp_rd_data (resp_rd_data),
        .mem_address  (mem_address),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
`ifdef BRAM_ARB_STATS_EN
        .stats_clear  (stats_clear),
        .grant_count  (grant_count),
`endif
        .mem_rd_data  (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural block memory: registered read-first port
    logic [WB-1:0] mem [32];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_address[6:2]];
        for (int b = 0; b < BW; b++)
            if (mem_wr_en[b]) mem[mem_address[6:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int            m_ptr;
    bit            m_pend;
    int            m_pid;
    logic [WB-1:0] m_pdata;
    logic [WB-1:0] shadow [32];
    int            last_acc;
    logic [N-1:0]  seen_ready;
    logic [N-1:0]  seen_resp_valid;
    logic [WB-1:0] seen_resp_data;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
    } vec_t;
    vec_t tab [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_rd_en   = '0;
        req_address = '0;
        req_wr_data = '0;
        req_wr_en   = '0;
    endtask

    task automatic set_req(input int i, input logic rd, input logic [AB-1:0] a,
                           input logic [WB-1:0] d, input logic [BW-1:0] we);
        req_valid[i]            = 1'b1;
        req_rd_en[i]            = rd;
        req_address[i*AB +: AB] = a;
        req_wr_data[i*WB +: WB] = d;
        req_wr_en[i*BW +: BW]   = we;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        m_ptr    = 0;
        m_pend   = 0;
        m_pdata  = '0;
        last_acc = -1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One clock cycle: compare outputs at the falling edge against the model,
    // then advance the model across the rising edge.
    task automatic step();
        int            g;
        int            word;
        logic [AB-1:0] a;
        logic [N-1:0]  eg;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        seen_ready      = req_ready;
        seen_resp_valid = resp_valid;
        seen_resp_data  = resp_rd_data;
        check("req_ready", req_ready, eg);
        check("resp_valid", resp_valid, m_pend ? (64'd1 << m_pid) : 64'd0);
        check("resp_rd_data", resp_rd_data, m_pend ? m_pdata : 32'd0);
        if (g >= 0) begin
            check("mem_address", mem_address, req_address[g*AB +: AB]);
            check("mem_rd_en", mem_rd_en, req_rd_en[g]);
            check("mem_wr_en", mem_wr_en, req_wr_en[g*BW +: BW]);
            check("mem_wr_data", mem_wr_data, req_wr_data[g*WB +: WB]);
        end else begin
            check("mem_rd_en_idle", mem_rd_en, 0);
            check("mem_wr_en_idle", mem_wr_en, 0);
        end
        m_pend = 0;
        if (g >= 0) begin
            a    = req_address[g*AB +: AB];
            word = int'(a[6:2]);
            if (req_rd_en[g]) begin
                m_pend  = 1;
                m_pid   = g;
                m_pdata = shadow[word];
            end
            for (int b = 0; b < BW; b++)
                if (req_wr_en[g*BW+b]) shadow[word][8*b +: 8] = req_wr_data[g*WB+8*b +: 8];
            m_ptr = (g + 1) % N;
        end
        last_acc = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < 32; w++) begin
            mem[w]    = 32'h5A5A_0000 + w * 32'h0001_0103;
            shadow[w] = mem[w];
        end
        mem[4]    = 32'hDEADBEEF;
        shadow[4] = 32'hDEADBEEF;
        mem[8]    = 32'hAABBCCDD;
        shadow[8] = 32'hAABBCCDD;
`ifdef BRAM_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        reset_n = 1'b1;
        clear_inputs();
        #1;
        do_reset();

        // Single read right after reset
        set_req(0, 1'b1, 7'h10, 32'h0, 4'h0);
        step();
        check("first_ready", seen_ready, 4'b0001);
        clear_inputs();
        step();
        check("first_resp_valid", seen_resp_valid, 4'b0001);
        check("first_resp_data", seen_resp_data, 32'hDEADBEEF);

        // Masked write then read of the same word on the next cycle
        clear_inputs();
        set_req(2, 1'b0, 7'h20, 32'h11223344, 4'b0101);
        step();
        check("wr_ready", seen_ready, 4'b0100);
        clear_inputs();
        set_req(0, 1'b1, 7'h20, 32'h0, 4'h0);
        step();
        check("wr_no_resp", seen_resp_valid, 4'b0000);
        clear_inputs();
        step();
        check("merge_resp_valid", seen_resp_valid, 4'b0001);
        check("merge_data", seen_resp_data, 32'hAA22CC44);

        // Vector table from a fresh pointer
        tab[0]  = '{4'b0001, 4'b0001};
        tab[1]  = '{4'b1111, 4'b0010};
        tab[2]  = '{4'b1111, 4'b0100};
        tab[3]  = '{4'b1111, 4'b1000};
        tab[4]  = '{4'b1111, 4'b0001};
        tab[5]  = '{4'b0000, 4'b0000};
        tab[6]  = '{4'b0010, 4'b0010};
        tab[7]  = '{4'b1010, 4'b1000};
        tab[8]  = '{4'b1010, 4'b0010};
        tab[9]  = '{4'b1010, 4'b1000};
        tab[10] = '{4'b0100, 4'b0100};
        tab[11] = '{4'b0011, 4'b0001};
        tab[12] = '{4'b0101, 4'b0100};
        tab[13] = '{4'b1001, 4'b1000};
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AB'(i * 12 + 1), 32'h0, 4'h0);
        for (int r = 0; r < 14; r++) begin
            req_valid = tab[r].valid;
            step();
            check($sformatf("tab_ready[%0d]", r), seen_ready, tab[r].exp_ready);
        end
        req_valid = '0;
        step();

        // Reset asserted mid-cycle while a read response is outstanding
        clear_inputs();
        set_req(1, 1'b1, 7'h08, 32'h0, 4'h0);
        step();
        check("rst_pre_resp", resp_valid, 4'b0010);
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 7'h04, 32'hFFFF_FFFF, 4'hF);
        #1;
        check("rst_resp_valid", resp_valid, 4'b0000);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_wr_en", mem_wr_en, 0);
        m_pend = 0;
        m_ptr  = 0;
        @(posedge clk);
        #1;
        check("rst_hold_ready", req_ready, 4'b0000);
        reset_n   = 1'b1;
        req_wr_en = '0;
        step();
        check("rst_ptr_zero", seen_ready, 4'b0001);
        clear_inputs();
        step();

`ifdef BRAM_ARB_STATS_EN
        stats_clear = 1'b1;
        @(posedge clk);
        #1 stats_clear = 1'b0;
        check("stats_cleared", grant_count, 64'd0);
        set_req(1, 1'b0, 7'h00, 32'h0, 4'h0);
        repeat (5) @(posedge clk);
        #1;
        check("stats_five", grant_count[31:16], 16'd5);
        repeat (69995) @(posedge clk);
        #1;
        check("stats_sat", grant_count[31:16], 16'hFFFF);
        check("stats_other", grant_count[15:0], 16'd0);
        stats_clear = 1'b1;
        @(posedge clk);
        #1 stats_clear = 1'b0;
        check("stats_clear_prio", grant_count[31:16], 16'd0);
        m_ptr  = 2;
        m_pend = 0;
        clear_inputs();
        step();
`endif

        // Randomized traffic respecting hold-until-accepted
        clear_inputs();
        last_acc = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (last_acc >= 0) req_valid[last_acc] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 60)
                    set_req(i, 1'($urandom_range(0, 1)), AB'($urandom_range(0, 127)),
                            $urandom, BW'($urandom_range(0, 15)));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bram_port_arbiter
`default_nettype wire

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one port of a dual-port block memory between `NUM_REQ` requesters (e.g. shader cores and a DMA engine). Each requester issues single-word read and/or byte-masked write requests over a valid/ready handshake. The arbiter drives the memory port for the granted requester and routes the one-cycle-later read data back with a per-requester response strobe. It sits between the requester fabric and a single memory port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CAPACITY_BYTES`, 128: memory size; `ADDR_BITS = $clog2(CAPACITY_BYTES)`.
- `BYTES_PER_WORD`, 4: `WORD_BITS = 8*BYTES_PER_WORD`.
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  request present, per requester.
- `req_ready`  out  NUM_REQ  grant; a request is accepted on `req_valid[i] & req_ready[i]`.
- `req_rd_en`  in  NUM_REQ  request includes a read.
- `req_address`  in  NUM_REQ×ADDR_BITS  byte address; low `$clog2(BYTES_PER_WORD)` bits are ignored.
- `req_wr_data`  in  NUM_REQ×WORD_BITS  write data.
- `req_wr_en`  in  NUM_REQ×BYTES_PER_WORD  byte write mask.
- `resp_valid`  out  NUM_REQ  read data valid for requester i.
- `resp_rd_data`  out  WORD_BITS  shared read-data bus.
- `mem_address`, `mem_rd_en`, `mem_wr_data`, `mem_wr_en`  out  ADDR_BITS / 1 / WORD_BITS / BYTES_PER_WORD  to the memory port.
- `mem_rd_data`  in  WORD_BITS  from the memory port; registered, 1-cycle latency.

## Operation
- Accept at most one request per cycle. `req_ready` is one-hot or zero, combinational from `req_valid` and the priority pointer `ptr`.
- Round-robin order: search upward from `ptr`, wrapping from `NUM_REQ-1` to 0. The first valid index wins.
- On acceptance of index g, `ptr <= (g+1) mod NUM_REQ`. With no acceptance, `ptr` holds.
- Handshake rules:
  - A requester holds `req_valid` and all payload stable until accepted.
  - `req_ready` never depends on `req_ready` of another requester.
- Memory port drive in the accepting cycle:
  - `mem_address`, `mem_wr_data`, `mem_wr_en` = payload of g.
  - `mem_rd_en = req_rd_en[g]`.
- Memory port drive with no grant: `mem_rd_en = 0`, `mem_wr_en = 0`; address and data are don't-care, driven with 0.
- Read+write in one request is legal. The response returns the pre-write contents (read-first).
- Write-only requests (`req_rd_en=0`) produce no response.
- Pending-response register stores `{pend_valid, pend_id}`, set on acceptance of a read.
- Next cycle: `resp_valid[pend_id]=1` and `resp_rd_data = mem_rd_data`. Otherwise `resp_rd_data` is 0.
- Back-to-back reads from different requesters give back-to-back responses in acceptance order.
- Requester with no valid: ignored, and `ptr` does not advance past it except by acceptance of a later index.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `ptr=0`, `pend_valid=0`.
  - `req_ready`, `resp_valid`, `mem_rd_en`, `mem_wr_en` are forced 0 while low.
  - A response pending at reset is dropped.
- First acceptance is possible in the first cycle after `reset_n` deasserts.
- Read latency: 1 cycle from the acceptance edge to `resp_valid`.
- Throughput: 1 request per cycle, sustained.
- Write commits at the acceptance edge. A read accepted next cycle to the same word sees the new data.

## Configuration
- `BRAM_ARB_STATS_EN` defined: adds input `stats_clear` (1 bit) and output `grant_count` (NUM_REQ×16).
  - Per-requester acceptance counters, saturating at 0xFFFF.
  - `stats_clear` is synchronous and zeroes all counters; it has priority over a simultaneous increment.
  - Counters reset to 0.
- `BRAM_ARB_STATS_EN` undefined: these ports and the counters are absent. Behaviour is otherwise identical.

## Structure
- Package `bram_arb_pkg`:
  - `MAX_REQ=8`
  - `GRANT_COUNT_BITS=16`
  - typedef `req_id_t` (logic [$clog2(MAX_REQ)-1:0])
- Sub-module `round_robin_picker`: combinational; inputs `valid`, `ptr`; outputs one-hot `grant`, `grant_id`, `any`. The arbiter owns all state.

## Test plan
- After reset: requester 0 reads address 0x10 (memory word 4 = 0xDEADBEEF) -> `req_ready[0]` same cycle; `resp_valid[0]=1`, `resp_rd_data=0xDEADBEEF` next cycle.
- All 4 valid continuously -> grants in order 0,1,2,3,0,… one per cycle; responses follow one cycle later with matching ids.
- Only requesters 1 and 3 valid, `ptr=2` -> grant 3 then 1, alternating.
- Requester 2 writes 0x11223344 with `wr_en=4'b0101` to a word holding 0xAABBCCDD, then requester 0 reads it the next cycle -> read returns 0xAA22CC44. The write produces no `resp_valid`.
- Read accepted, then `reset_n` pulsed low mid-cycle -> no `resp_valid`, `ptr=0` after release.
- With `BRAM_ARB_STATS_EN`: 70000 grants to requester 1 -> `grant_count[1]=0xFFFF`; then `stats_clear` -> 0.
